// File: rtl/ram_mp_clr_pkg.sv
// Shared definitions for the multi-port RAM with clear sequencer.
// Holds the sequencer state encoding and the read-during-write mode constants.
package ram_mp_clr_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } clr_state_e;

  localparam int unsigned RdFirst = 0;
  localparam int unsigned WrFirst = 1;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps zeroes through the whole array after reset and on request.
// Provides the sweep write strobe/address and the busy flag.
module ram_clr_seq
  import ram_mp_clr_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  output logic                     busy_o,
  output logic                     clr_we_o,
  output logic [ADDRESS_WIDTH-1:0] clr_addr_o
);

  clr_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        // Last word written this cycle; pointer wraps to 0 but the state leaves CLEAR.
        if (ptr_q == '1) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (clr_i) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy_o     = (state_q == StClear);
  assign clr_we_o   = (state_q == StClear);
  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/ram_mp_clr.sv
// Synchronous RAM: one write port, NUM_RD registered read ports with valid flags,
// selectable read-during-write behaviour and a built-in clear sweep.
module ram_mp_clr
  import ram_mp_clr_pkg::*;
#(
  parameter int unsigned BUS_WIDTH     = 8,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned NUM_RD        = 2,
  parameter int unsigned WR_MODE       = RdFirst
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            st,
  input  logic [ADDRESS_WIDTH-1:0]        ad,
  input  logic [BUS_WIDTH-1:0]            X,
  input  logic [NUM_RD-1:0]               rd_en,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_ad,
  output logic [NUM_RD*BUS_WIDTH-1:0]     rd_data,
  output logic [NUM_RD-1:0]               rd_valid,
  output logic                            busy
);

  localparam int unsigned Depth = 1 << ADDRESS_WIDTH;

  logic                     clr_we;
  logic [ADDRESS_WIDTH-1:0] clr_addr;
  logic                     user_we;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0]     mem_wdata;
  logic [BUS_WIDTH-1:0]     mem [Depth];

  ram_clr_seq #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_clr_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  // clr beats st in the same cycle: that word is about to be zeroed anyway.
  assign user_we   = !busy && st && !clr;
  assign mem_we    = clr_we || user_we;
  assign mem_addr  = clr_we ? clr_addr : ad;
  assign mem_wdata = clr_we ? '0 : X;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] raddr;
    logic                     fwd;
    logic                     rd_go;
    logic [BUS_WIDTH-1:0]     data_q;
    logic                     valid_q;

    assign raddr = rd_ad[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign rd_go = rd_en[k] && !busy;
    // Write-first forwards the incoming word; read-first sees the old array value.
    assign fwd   = (WR_MODE == WrFirst) && user_we && (raddr == ad);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_go;
        if (rd_go) begin
          data_q <= fwd ? X : mem[raddr];
        end
      end
    end

    assign rd_data[k*BUS_WIDTH +: BUS_WIDTH] = data_q;
    assign rd_valid[k]                       = valid_q;
  end

endmodule

// File: tb/tb_ram_mp_clr.sv
// Self-checking bench for ram_mp_clr: read-first and write-first instances share stimulus,
// a reference memory/sweep model feeds a scoreboard of expected read data.
module tb_ram_mp_clr;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        st;
  logic [7:0]  ad;
  logic [7:0]  X;
  logic [1:0]  rd_en;
  logic [15:0] rd_ad;
  logic [15:0] rdata_rf, rdata_wf;
  logic [1:0]  rvalid_rf, rvalid_wf;
  logic        busy_rf, busy_wf;

  ram_mp_clr #(
    .BUS_WIDTH    (8),
    .ADDRESS_WIDTH(8),
    .NUM_RD       (2),
    .WR_MODE      (0)
  ) u_dut_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .st      (st),
    .ad      (ad),
    .X       (X),
    .rd_en   (rd_en),
    .rd_ad   (rd_ad),
    .rd_data (rdata_rf),
    .rd_valid(rvalid_rf),
    .busy    (busy_rf)
  );

  ram_mp_clr #(
    .BUS_WIDTH    (8),
    .ADDRESS_WIDTH(8),
    .NUM_RD       (2),
    .WR_MODE      (1)
  ) u_dut_wf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .st      (st),
    .ad      (ad),
    .X       (X),
    .rd_en   (rd_en),
    .rd_ad   (rd_ad),
    .rd_data (rdata_wf),
    .rd_valid(rvalid_wf),
    .busy    (busy_wf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [7:0] e_rf;
    logic [7:0] e_wf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_mem [256];
  bit         m_busy;
  int         m_ptr;
  logic [7:0] hold_rf [2];
  logic [7:0] hold_wf [2];
  bit         exp_vld [2];
  int         n_vec;
  int         n_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("busy_rf", {7'b0, busy_rf}, {7'b0, m_busy});
    chk("busy_wf", {7'b0, busy_wf}, {7'b0, m_busy});
    chk("valid_rf", {6'b0, rvalid_rf}, {6'b0, exp_vld[1], exp_vld[0]});
    chk("valid_wf", {6'b0, rvalid_wf}, {6'b0, exp_vld[1], exp_vld[0]});
    chk("data_rf_p0", rdata_rf[7:0], hold_rf[0]);
    chk("data_rf_p1", rdata_rf[15:8], hold_rf[1]);
    chk("data_wf_p0", rdata_wf[7:0], hold_wf[0]);
    chk("data_wf_p1", rdata_wf[15:8], hold_wf[1]);
  endtask

  // Model state as it stands right after an asynchronous reset.
  task automatic model_reset();
    m_busy = 1'b1;
    m_ptr  = 0;
    sb.delete();
    for (int k = 0; k < 2; k++) begin
      hold_rf[k] = 8'h00;
      hold_wf[k] = 8'h00;
      exp_vld[k] = 1'b0;
    end
  endtask

  // One clock with the currently driven inputs; outputs checked #1 after the edge.
  task automatic cycle();
    exp_t       e;
    logic [7:0] a;
    for (int k = 0; k < 2; k++) begin
      exp_vld[k] = !m_busy && rd_en[k];
      if (exp_vld[k]) begin
        a      = rd_ad[k*8 +: 8];
        e.port = k;
        e.e_rf = model_mem[a];
        e.e_wf = (st && !clr && (a == ad)) ? X : model_mem[a];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (m_busy) begin
      model_mem[m_ptr] = 8'h00;
      m_ptr++;
      if (m_ptr == 256) m_busy = 1'b0;
    end else if (clr) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end else if (st) begin
      model_mem[ad] = X;
    end
    for (int k = 0; k < 2; k++) begin
      if (exp_vld[k]) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
          e          = sb.pop_front();
          hold_rf[k] = e.e_rf;
          hold_wf[k] = e.e_wf;
        end
      end
    end
    check_outputs();
  endtask

  task automatic idle_inputs();
    clr   = 1'b0;
    st    = 1'b0;
    ad    = 8'h00;
    X     = 8'h00;
    rd_en = 2'b00;
    rd_ad = 16'h0000;
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    st = 1'b1;
    ad = a;
    X  = d;
    cycle();
    st = 1'b0;
  endtask

  task automatic read2(input logic [1:0] en, input logic [7:0] a0, input logic [7:0] a1);
    rd_en = en;
    rd_ad = {a1, a0};
    cycle();
    rd_en = 2'b00;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'hxx;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Initial sweep: busy for exactly 256 edges.
    repeat (256) cycle();

    read2(2'b11, 8'd0, 8'd17);
    read2(2'b01, 8'd255, 8'd0);
    cycle();

    // Basic write/read, valid drops with rd_en.
    write(8'h10, 8'hA5);
    read2(2'b01, 8'h10, 8'h00);
    cycle();

    write(8'h20, 8'h11);
    write(8'h01, 8'h3C);
    write(8'h02, 8'hC3);
    write(8'h05, 8'h55);

    // Read-during-write on both ports.
    st = 1'b1;
    ad = 8'h20;
    X  = 8'h22;
    read2(2'b11, 8'h20, 8'h20);
    st = 1'b0;
    read2(2'b11, 8'h20, 8'h20);

    // Independent ports; then write on one address while reading another.
    read2(2'b11, 8'h01, 8'h02);
    st = 1'b1;
    ad = 8'h30;
    X  = 8'h99;
    read2(2'b11, 8'h02, 8'h30);
    st = 1'b0;
    read2(2'b10, 8'h00, 8'h30);

    // clr together with st: clr wins; activity during the sweep is ignored.
    read2(2'b01, 8'h05, 8'h00);
    clr = 1'b1;
    st  = 1'b1;
    ad  = 8'h05;
    X   = 8'h77;
    cycle();
    clr   = 1'b0;
    rd_en = 2'b11;
    rd_ad = 16'h0505;
    for (int i = 0; i < 256; i++) begin
      clr = (i == 50);
      cycle();
    end
    idle_inputs();
    read2(2'b11, 8'h05, 8'h10);
    cycle();

    // Reset asserted mid-sweep.
    write(8'h40, 8'h6E);
    read2(2'b01, 8'h40, 8'h00);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    repeat (100) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    repeat (256) cycle();
    read2(2'b11, 8'h40, 8'h10);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_mp_clr.md
Name: ram_mp_clr

Overview:
- Parametrised synchronous RAM: one write port, NUM_RD independent read ports, registered read data with valid flags.
- Selectable read-during-write mode.
- Built-in clear sequencer zeroes the array after reset and on request.
- Successor to the flat single-port register-array RAM; used as register-file and scratch storage in the datapath.

Parameters:
- BUS_WIDTH, 8, data word width in bits.
- ADDRESS_WIDTH, 8, address width in bits; DEPTH = 1<<ADDRESS_WIDTH words.
- NUM_RD, 2, number of read ports (1..4).
- WR_MODE, 0, read-during-write on same address: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  single-cycle request to re-zero the whole array.
- st  in  1  write enable.
- ad  in  ADDRESS_WIDTH  write address.
- X  in  BUS_WIDTH  write data.
- rd_en  in  NUM_RD  per-port read enable.
- rd_ad  in  NUM_RD*ADDRESS_WIDTH  packed read addresses; port k at bits [k*AW +: AW].
- rd_data  out  NUM_RD*BUS_WIDTH  packed registered read data; port k at bits [k*BW +: BW].
- rd_valid  out  NUM_RD  per-port read data valid, one-cycle pulse.
- busy  out  1  high while clear sweep in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_data = 0, rd_valid = 0, busy = 1.
  - State = CLEAR, sweep pointer = 0.
  - Array contents are not reset directly; the sweep zeroes them.
- FSM has two states:
  - CLEAR: each cycle writes 0 to array[ptr], ptr++. At ptr == DEPTH-1 the last word is written and the next state is READY; busy drops the cycle after. Sweep takes exactly DEPTH cycles after rst_n deasserts.
  - READY: normal operation. clr=1 -> CLEAR with ptr = 0 next cycle; busy rises the next cycle.
- While busy:
  - st is ignored; no user writes.
  - rd_en is ignored; rd_valid = 0, rd_data holds its value.
  - clr is ignored; the sweep is not restarted.
- clr and st in the same READY cycle: clr wins, write dropped. The address would be zeroed anyway.
- Write: in READY with st=1 and clr=0, array[ad] <= X at the rising edge.
- Read:
  - In READY with rd_en[k]=1, rd_data[k] <= array[rd_ad[k]] and rd_valid[k] <= 1. Latency 1 cycle.
  - With rd_en[k]=0, rd_valid[k] <= 0 and rd_data[k] holds.
- Read-during-write (same cycle, rd_ad[k] == ad, st=1):
  - WR_MODE=0: port k returns pre-write contents.
  - WR_MODE=1: port k returns X.
  - Other ports/addresses are unaffected.
- Multiple read ports on the same address are legal and return identical data.
- Address range: full, no out-of-range case. ptr is ADDRESS_WIDTH+1 bits wide or compared at DEPTH-1; it must not wrap to restart the sweep.
- Reset mid-sweep: restarts at ptr = 0, busy stays 1.

Decomposition:
- Shared include ram_defs.vh holds:
  - state encodings S_CLEAR = 1'b0, S_READY = 1'b1.
  - WR_MODE constants RD_FIRST = 0, WR_FIRST = 1.
- Sub-module ram_clr_seq contains the FSM, sweep pointer and busy generation.
  - Outputs: clear write enable, clear address.
  - Top level muxes clear vs user write into the array.
- Read ports are produced by a generate loop over NUM_RD.

Test Plan:
- Reset release -> busy=1 for 256 cycles (default params), then 0; read of addresses 0, 17, 255 afterwards returns 0x00 with rd_valid one cycle after rd_en.
- After busy falls: write 0xA5 to 0x10, then rd_en[0] with rd_ad[0]=0x10 -> rd_data[0]=0xA5, rd_valid[0]=1 next cycle; rd_valid drops when rd_en drops.
- Array holds 0x11 at 0x20; st with X=0x22 at ad=0x20 and both ports reading 0x20 in the same cycle -> WR_MODE=0 both ports return 0x11; WR_MODE=1 both return 0x22; a following read returns 0x22 in either mode.
- Port 0 reads 0x01 (holding 0x3C) while port 1 reads 0x02 (holding 0xC3) in the same cycle -> independent data, both valid.
- Array holds 0x55 at 0x05; clr pulse together with st of 0x77 to 0x05 -> busy=1 for 256 cycles, writes/reads during sweep ignored (rd_valid=0); afterwards 0x05 reads 0x00.
- rst_n asserted at sweep cycle 100 -> outputs cleared immediately; busy=1 for a full 256 cycles after release.
